// File: rtl/spwm_pkg.sv
// rtl/spwm_pkg.sv - shared state type, widths and defaults for the SPWM sequencer
package spwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_CARRIER_TOP     = 5000;
  localparam int DEF_THETA_MAX       = 88;
  localparam int DEF_STEPS_PER_THETA = 1;
  localparam int DEF_GAP_CYCLES      = 500000;

  localparam int CNT_W   = 13;
  localparam int THETA_W = 10;
  localparam int STEP_W  = 16;
  localparam int GAP_W   = 20;

  // Table values above one full carrier period would only ever mean "always high".
  function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] x,
                                                  input logic [CNT_W-1:0] lim);
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/spwm_carrier.sv
// rtl/spwm_carrier.sv - carrier counter, duty register and registered compare
module spwm_carrier import spwm_pkg::*; #(
  parameter int CARRIER_TOP = DEF_CARRIER_TOP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic             run_next,
  input  logic [CNT_W-1:0] sine_in,
  output logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  localparam logic [CNT_W-1:0] TOP_V    = CNT_W'(CARRIER_TOP);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(CARRIER_TOP + 1);

  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] duty_n;
  logic             pwm_n;

  // Next counter/duty; pwm is computed from next values so it lines up with cnt.
  always_comb begin
    cnt_n  = '0;
    duty_n = duty_q;
    if (run && (cnt != TOP_V)) begin
      cnt_n = cnt + 1'b1;
    end
    if (load || (run && (cnt == TOP_V))) begin
      duty_n = clamp_duty(sine_in, DUTY_MAX);
    end
    pwm_n = run_next && (cnt_n < duty_n);
  end

  // Carrier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      duty_q <= duty_n;
      pwm    <= pwm_n;
    end
  end

endmodule

// File: rtl/spwm_seq.sv
// rtl/spwm_seq.sv - SPWM half-cycle sequencer with dead-time gap
module spwm_seq import spwm_pkg::*; #(
  parameter int CARRIER_TOP     = DEF_CARRIER_TOP,
  parameter int THETA_MAX       = DEF_THETA_MAX,
  parameter int STEPS_PER_THETA = DEF_STEPS_PER_THETA,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [THETA_W-1:0] theta,
  input  logic [CNT_W-1:0]   sine_in,
  output logic               pwm,
  output logic               phase,
  output logic               period_start,
  output logic               half_done,
  output logic               busy
);

  localparam logic [CNT_W-1:0]   TOP_V      = CNT_W'(CARRIER_TOP);
  localparam logic [CNT_W-1:0]   PRE_V      = CNT_W'(CARRIER_TOP - 1);
  localparam logic [THETA_W-1:0] THETA_LAST = THETA_W'(THETA_MAX);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_PER_THETA - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [STEP_W-1:0]  step_cnt, step_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [THETA_W-1:0] theta_n;
  logic               end_half, end_half_n;
  logic               stop_q, stop_n;
  logic               phase_n, ps_n, hd_n;
  logic               at_top, at_pre;

  assign at_top = (state == ST_RUN) && (cnt == TOP_V);
  assign at_pre = (state == ST_RUN) && (cnt == PRE_V);

  spwm_carrier #(.CARRIER_TOP(CARRIER_TOP)) u_carrier (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state == ST_RUN),
    .load     ((state != ST_RUN) && (state_n == ST_RUN)),
    .run_next (state_n == ST_RUN),
    .sine_in  (sine_in),
    .cnt      (cnt),
    .pwm      (pwm)
  );

  // Next-state, theta stepping and pulse generation; a stop request is latched so
  // a late re-enable cannot cancel it before the wrap.
  always_comb begin
    state_n    = state;
    theta_n    = theta;
    step_n     = step_cnt;
    gap_n      = gap_cnt;
    end_half_n = end_half;
    stop_n     = stop_q;
    phase_n    = phase;
    ps_n       = 1'b0;
    hd_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n    = ST_RUN;
          theta_n    = '0;
          step_n     = '0;
          end_half_n = 1'b0;
          stop_n     = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          stop_n = 1'b1;
        end
        if (at_pre) begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            if (theta == THETA_LAST) begin
              theta_n    = '0;
              end_half_n = 1'b1;
            end else begin
              theta_n = theta + 1'b1;
            end
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
        if (at_top) begin
          if (end_half) begin
            state_n    = ST_GAP;
            end_half_n = 1'b0;
            stop_n     = 1'b0;
            gap_n      = '0;
            hd_n       = 1'b1;
          end else if (stop_q || !enable) begin
            state_n = ST_IDLE;
            stop_n  = 1'b0;
          end else begin
            ps_n = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_n = ST_IDLE;
          gap_n   = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = ST_RUN;
          phase_n = ~phase;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      theta        <= '0;
      step_cnt     <= '0;
      gap_cnt      <= '0;
      end_half     <= 1'b0;
      stop_q       <= 1'b0;
      phase        <= 1'b0;
      period_start <= 1'b0;
      half_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      theta        <= theta_n;
      step_cnt     <= step_n;
      gap_cnt      <= gap_n;
      end_half     <= end_half_n;
      stop_q       <= stop_n;
      phase        <= phase_n;
      period_start <= ps_n;
      half_done    <= hd_n;
      busy         <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spwm_seq.sv
// tb/tb_spwm_seq.sv - self-checking bench for spwm_seq
module tb_spwm_seq;

  typedef struct packed {
    logic       pwm;
    logic       phase;
    logic       ps;
    logic       hd;
    logic       busy;
    logic [9:0] theta;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        enable3 = 1'b0;
  logic [9:0]  theta, theta3;
  logic [12:0] sine_in, sine3;
  logic        pwm, phase, period_start, half_done, busy;
  logic        pwm3, phase3, period_start3, half_done3, busy3;
  logic [12:0] tbl [4];
  int          duty_of [4] = '{0, 5, 10, 5};
  obs_t        obs, obs3;
  obs_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always_comb sine_in = (theta < 10'd4) ? tbl[theta[1:0]] : 13'd0;
  always_comb sine3   = (theta3 < 10'd4) ? tbl[theta3[1:0]] : 13'd0;

  assign obs  = {pwm, phase, period_start, half_done, busy, theta};
  assign obs3 = {pwm3, phase3, period_start3, half_done3, busy3, theta3};

  spwm_seq #(.CARRIER_TOP(9), .THETA_MAX(3), .STEPS_PER_THETA(1), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .theta(theta), .sine_in(sine_in),
    .pwm(pwm), .phase(phase), .period_start(period_start), .half_done(half_done), .busy(busy)
  );

  spwm_seq #(.CARRIER_TOP(9), .THETA_MAX(3), .STEPS_PER_THETA(3), .GAP_CYCLES(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable3), .theta(theta3), .sine_in(sine3),
    .pwm(pwm3), .phase(phase3), .period_start(period_start3), .half_done(half_done3), .busy(busy3)
  );

  task automatic push_period(input int duty, input int th, input int th_next,
                             input bit ps_first, input bit ph);
    obs_t e;
    for (int c = 0; c < 10; c++) begin
      e.pwm   = (c < duty);
      e.phase = ph;
      e.ps    = ps_first && (c == 0);
      e.hd    = 1'b0;
      e.busy  = 1'b1;
      e.theta = (c == 9) ? 10'(th_next) : 10'(th);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_gap(input int n, input bit ph, input int th);
    obs_t e;
    for (int g = 0; g < n; g++) begin
      e.pwm   = 1'b0;
      e.phase = ph;
      e.ps    = 1'b0;
      e.hd    = (g == 0);
      e.busy  = 1'b1;
      e.theta = 10'(th);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n, input bit ph, input int th);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e       = '0;
      e.phase = ph;
      e.theta = 10'(th);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_half(input bit ph);
    for (int p = 0; p < 4; p++) begin
      push_period(duty_of[p], p, (p + 1) % 4, p > 0, ph);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    enable3 = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", obs, obs_t'(0));
    end
    checks++;
    if (obs3 !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_hold3 got=%h exp=%h", obs3, obs_t'(0));
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", obs, obs_t'(0));
    end
  endtask

  task automatic test_basic();
    obs_t e;
    do_reset();
    enable = 1'b1;
    push_half(1'b0);
    push_gap(4, 1'b0, 0);
    push_period(0, 0, 1, 1'b0, 1'b1);
    push_period(5, 1, 2, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_clamp();
    obs_t e;
    do_reset();
    tbl[2] = 13'd8000;
    enable = 1'b1;
    push_period(0, 0, 1, 1'b0, 1'b0);
    push_period(5, 1, 2, 1'b1, 1'b0);
    push_period(10, 2, 3, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clamp cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    tbl[2] = 13'd10;
  endtask

  task automatic test_stop();
    obs_t e;
    do_reset();
    enable = 1'b1;
    push_period(0, 0, 1, 1'b0, 1'b0);
    push_period(5, 1, 2, 1'b1, 1'b0);
    push_idle(3, 1'b0, 2);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 13) enable = 1'b0;
    end
  endtask

  task automatic test_rearm();
    obs_t e;
    do_reset();
    tbl[2] = 13'd0;
    enable = 1'b1;
    push_period(0, 0, 1, 1'b0, 1'b0);
    push_period(5, 1, 2, 1'b1, 1'b0);
    push_idle(1, 1'b0, 2);
    push_period(0, 0, 1, 1'b0, 1'b0);
    push_period(5, 1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rearm cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 13) enable = 1'b0;
      if (i == 19) enable = 1'b1;
    end
    tbl[2] = 13'd10;
  endtask

  task automatic test_gap_stop();
    obs_t e;
    do_reset();
    enable = 1'b1;
    push_half(1'b0);
    push_gap(2, 1'b0, 0);
    push_idle(3, 1'b0, 0);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL gap_stop cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 41) enable = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    do_reset();
    enable = 1'b1;
    push_half(1'b0);
    push_gap(4, 1'b0, 0);
    push_period(0, 0, 1, 1'b0, 1'b1);
    push_period(5, 1, 2, 1'b1, 1'b1);
    push_period(10, 2, 3, 1'b1, 1'b1);
    for (int i = 0; i < 69; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL areset_now got=%h exp=%h", obs, obs_t'(0));
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL areset_idle got=%h exp=%h", obs, obs_t'(0));
    end
    enable = 1'b1;
    push_period(0, 0, 1, 1'b0, 1'b0);
    push_period(5, 1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_restart cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_step_hold();
    obs_t e;
    do_reset();
    enable3 = 1'b1;
    for (int p = 0; p < 12; p++) begin
      push_period(duty_of[p / 3], p / 3, (p % 3 == 2) ? ((p / 3 + 1) % 4) : (p / 3), p > 0, 1'b0);
    end
    push_gap(4, 1'b0, 0);
    for (int i = 0; i < 124; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs3 !== e) begin
        errors++;
        $display("FAIL step_hold cyc=%0d got=%h exp=%h", i, obs3, e);
      end
    end
    enable3 = 1'b0;
  endtask

  initial begin
    tbl[0] = 13'd0;
    tbl[1] = 13'd5;
    tbl[2] = 13'd10;
    tbl[3] = 13'd5;
    test_reset();
    test_basic();
    test_clamp();
    test_stop();
    test_rearm();
    test_gap_stop();
    test_async_reset();
    test_step_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
